// File: rtl/relfet_cpu_core.sv
// Reflet-style accumulator CPU core: 16 registers (WR, SR, SP, PC among them),
// 8-bit instructions, and a multi-cycle FSM against a 1-cycle-latency memory.
module relfet_cpu_core #(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [wordsize-1:0] data_in,
    input  logic [3:0]          ext_int,
    output logic [wordsize-1:0] addr,
    output logic [wordsize-1:0] data_out,
    output logic                write_en,
    output logic                quit
);
    localparam int W = wordsize;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_MEMWAIT,
        S_QUIT
    } state_t;

    state_t         state, state_next;
    logic [W-1:0]   regs [16];
    logic [7:0]     ir;
    logic [W-1:0]   mem_addr;
    logic [W-1:0]   st_data;
    logic           is_store;

    logic [3:0]     opcode, x;
    logic [W-1:0]   wr, rx, pc, sp, pc_inc;
    logic           mem_op;
    logic           unused_ext;

    assign unused_ext = ^ext_int;

    assign opcode = data_in[7:4];
    assign x      = data_in[3:0];
    assign wr     = regs[0];
    assign rx     = regs[x];
    assign pc     = regs[14];
    assign sp     = regs[13];
    assign pc_inc = pc + 1'b1;
    assign mem_op = (opcode == 4'hE) || (opcode == 4'hF) ||
                    ((opcode == 4'h0) && (x >= 4'h4) && (x <= 4'h7));

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else if (enable)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        addr       = pc;
        data_out   = st_data;
        write_en   = 1'b0;
        case (state)
            S_FETCH:   state_next = S_DECODE;
            S_DECODE: begin
                if (data_in[7:0] == 8'h08)
                    state_next = S_QUIT;
                else if (mem_op)
                    state_next = S_MEM;
                else
                    state_next = S_FETCH;
            end
            S_MEM: begin
                addr       = mem_addr;
                write_en   = is_store && enable && !reset;
                state_next = S_MEMWAIT;
            end
            S_MEMWAIT: begin
                addr       = mem_addr;
                state_next = S_FETCH;
            end
            S_QUIT:    state_next = S_QUIT;
            default:   state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 16; i++)
                regs[i] <= '0;
            ir       <= '0;
            mem_addr <= '0;
            st_data  <= '0;
            is_store <= 1'b0;
            quit     <= 1'b0;
        end else if (enable) begin
            case (state)
                S_DECODE: begin
                    ir       <= data_in[7:0];
                    regs[14] <= pc_inc;
                    case (opcode)
                        4'h0: begin
                            case (x)
                                4'h1: regs[12][0] <= ~regs[12][0];
                                4'h3: if (regs[12][0]) regs[14] <= wr;
                                4'h4, 4'h7: begin
                                    mem_addr <= sp;
                                    regs[13] <= sp + 1'b1;
                                    is_store <= 1'b0;
                                end
                                4'h5: begin
                                    mem_addr <= sp - 1'b1;
                                    regs[13] <= sp - 1'b1;
                                    st_data  <= wr;
                                    is_store <= 1'b1;
                                end
                                4'h6: begin
                                    mem_addr <= sp - 1'b1;
                                    regs[13] <= sp - 1'b1;
                                    st_data  <= pc_inc;
                                    is_store <= 1'b1;
                                    regs[14] <= wr;
                                end
                                4'h8:    quit <= 1'b1;
                                default: ;
                            endcase
                        end
                        4'h1: regs[0] <= {{(W-4){1'b0}}, x};
                        4'h2: regs[0] <= rx;
                        // later NBA wins: cpy R14 overrides the PC increment (jump), cpy R0 rewrites WR
                        4'h3: regs[x] <= wr;
                        4'h4: regs[0] <= wr + rx;
                        4'h5: regs[0] <= wr - rx;
                        4'h6: regs[0] <= wr & rx;
                        4'h7: regs[0] <= wr | rx;
                        4'h8: regs[0] <= wr ^ rx;
                        4'h9: regs[0] <= ~rx;
                        4'hA: regs[0] <= wr << rx;
                        4'hB: regs[0] <= wr >> rx;
                        4'hC: regs[12][0] <= (wr == rx);
                        4'hD: regs[12][0] <= (wr < rx);
                        4'hE: begin
                            mem_addr <= rx;
                            st_data  <= wr;
                            is_store <= 1'b1;
                        end
                        4'hF: begin
                            mem_addr <= rx;
                            is_store <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_MEMWAIT: begin
                    if (!is_store) begin
                        if (ir == 8'h07)
                            regs[14] <= data_in;
                        else
                            regs[0] <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_relfet_cpu_core.sv
// Directed bench for relfet_cpu_core (W=8) with a 1-cycle-latency memory model:
// a table of small programs plus freeze and reset corner sequences.
module tb_relfet_cpu_core;
    typedef logic [7:0] prog_t [16];

    typedef struct {
        string      name;
        prog_t      prog;
        logic [7:0] wr;
        logic [7:0] sp;
        int         writes;
        logic [7:0] waddr;
        logic [7:0] wdata;
        int         cycles;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] data_in = '0;
    logic [3:0] ext_int = 4'hA;
    logic [7:0] addr, data_out;
    logic       write_en, quit;

    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load_mem = 1'b0;
    logic       mon_clr = 1'b0;
    int         wr_count;
    logic [7:0] last_addr, last_data;

    int n_checks = 0;
    int n_fail = 0;
    vec_t vq[$];

    relfet_cpu_core #(.wordsize(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .data_in  (data_in),
        .ext_int  (ext_int),
        .addr     (addr),
        .data_out (data_out),
        .write_en (write_en),
        .quit     (quit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= img[i];
        end else if (write_en) begin
            mem[addr] <= data_out;
        end
        data_in <= mem[addr];
        if (mon_clr) begin
            wr_count <= 0;
        end else if (write_en) begin
            wr_count  <= wr_count + 1;
            last_addr <= addr;
            last_data <= data_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input prog_t p, input logic [7:0] wr,
                           input logic [7:0] sp, input int writes, input logic [7:0] waddr,
                           input logic [7:0] wdata, input int cycles);
        vec_t v;
        v.name = name; v.prog = p; v.wr = wr; v.sp = sp; v.writes = writes;
        v.waddr = waddr; v.wdata = wdata; v.cycles = cycles;
        vq.push_back(v);
    endtask

    // Loads the image under reset, checks the reset state, then releases reset.
    task automatic start_prog(input string name, input prog_t p);
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 256; i++)
            img[i] = (i < 16) ? p[i] : 8'h00;
        load_mem = 1'b1;
        mon_clr  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_mem = 1'b0;
        mon_clr  = 1'b0;
        check({name, "/rst_addr"}, 32'(addr), 32'h0);
        check({name, "/rst_quit"}, 32'(quit), 32'h0);
        check({name, "/rst_we"}, 32'(write_en), 32'h0);
        reset = 1'b0;
    endtask

    task automatic wait_quit(input string name, output int cycles);
        cycles = 0;
        while (cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (quit) break;
        end
        check({name, "/quit_reached"}, 32'(quit), 32'h1);
    endtask

    task automatic wait_addr(input string name, input logic [7:0] a);
        int n = 0;
        while (addr !== a && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "/addr_reached"}, 32'(addr), 32'(a));
    endtask

    prog_t p027;

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            img[i] = 8'h00;
        end

        add_vec("add",     '{0:8'h15, 1:8'h31, 2:8'h13, 3:8'h41, 4:8'h08, default:8'h00}, 8'h08, 8'h00, 0, 8'h00, 8'h00, 10);
        add_vec("str",     '{0:8'h17, 1:8'h32, 2:8'h19, 3:8'hE2, 4:8'h08, default:8'h00}, 8'h09, 8'h00, 1, 8'h07, 8'h09, 12);
        add_vec("pushpop", '{0:8'h16, 1:8'h05, 2:8'h10, 3:8'h04, 4:8'h08, default:8'h00}, 8'h06, 8'h00, 1, 8'hFF, 8'h06, 14);
        add_vec("sub",     '{0:8'h13, 1:8'h31, 2:8'h11, 3:8'h51, 4:8'h08, default:8'h00}, 8'hFE, 8'h00, 0, 8'h00, 8'h00, 10);
        add_vec("not",     '{0:8'h15, 1:8'h32, 2:8'h92, 3:8'h08, default:8'h00}, 8'hFA, 8'h00, 0, 8'h00, 8'h00, 8);
        add_vec("shifts",  '{0:8'h12, 1:8'h34, 2:8'h13, 3:8'hA4, 4:8'hB4, 5:8'h08, default:8'h00}, 8'h03, 8'h00, 0, 8'h00, 8'h00, 12);
        add_vec("load",    '{0:8'h1A, 1:8'h35, 2:8'hF5, 3:8'h08, 10:8'h5C, default:8'h00}, 8'h5C, 8'h00, 0, 8'h00, 8'h00, 10);
        add_vec("read_pc", '{0:8'h10, 1:8'h10, 2:8'h2E, 3:8'h08, default:8'h00}, 8'h02, 8'h00, 0, 8'h00, 8'h00, 8);
        add_vec("les",     '{0:8'h13, 1:8'h31, 2:8'h12, 3:8'hD1, 4:8'h2C, 5:8'h08, default:8'h00}, 8'h01, 8'h00, 0, 8'h00, 8'h00, 12);
        add_vec("and_or",  '{0:8'h1C, 1:8'h31, 2:8'h1A, 3:8'h61, 4:8'h71, 5:8'h08, default:8'h00}, 8'h0C, 8'h00, 0, 8'h00, 8'h00, 12);
        add_vec("xor",     '{0:8'h15, 1:8'h31, 2:8'h13, 3:8'h81, 4:8'h08, default:8'h00}, 8'h06, 8'h00, 0, 8'h00, 8'h00, 10);
        add_vec("callret", '{0:8'h16, 1:8'h06, 2:8'h08, 6:8'h15, 7:8'h07, default:8'h00}, 8'h05, 8'h00, 1, 8'hFF, 8'h02, 14);
        add_vec("jif_tkn", '{0:8'h14, 1:8'h33, 2:8'h14, 3:8'hC3, 4:8'h1A, 5:8'h03, 6:8'h1F, 7:8'h08, 10:8'h08, default:8'h00}, 8'h0A, 8'h00, 0, 8'h00, 8'h00, 14);
        add_vec("jif_nt",  '{0:8'h14, 1:8'h33, 2:8'h14, 3:8'hC3, 4:8'h01, 5:8'h1A, 6:8'h03, 7:8'h1F, 8:8'h08, 10:8'h08, default:8'h00}, 8'h0F, 8'h00, 0, 8'h00, 8'h00, 18);

        // Each vector starts with a reset, so every run after the first also resets out of quit.
        foreach (vq[i]) begin
            start_prog(vq[i].name, vq[i].prog);
            wait_quit(vq[i].name, cyc);
            check({vq[i].name, "/cycles"}, 32'(cyc), 32'(vq[i].cycles));
            check({vq[i].name, "/wr"}, 32'(dut.regs[0]), 32'(vq[i].wr));
            check({vq[i].name, "/sp"}, 32'(dut.regs[13]), 32'(vq[i].sp));
            check({vq[i].name, "/writes"}, 32'(wr_count), 32'(vq[i].writes));
            if (vq[i].writes > 0) begin
                check({vq[i].name, "/waddr"}, 32'(last_addr), 32'(vq[i].waddr));
                check({vq[i].name, "/wdata"}, 32'(last_data), 32'(vq[i].wdata));
            end
            repeat (3) @(negedge clk);
            check({vq[i].name, "/quit_sticky"}, 32'(quit), 32'h1);
            check({vq[i].name, "/halt_we"}, 32'(write_en), 32'h0);
        end

        p027 = vq[1].prog;

        // Freeze while the store is on the bus: no write, nothing moves, then completes normally.
        start_prog("freeze", p027);
        wait_addr("freeze", 8'h07);
        enable = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("freeze/addr", 32'(addr), 32'h07);
            check("freeze/we", 32'(write_en), 32'h0);
            check("freeze/wr", 32'(dut.regs[0]), 32'h09);
            check("freeze/writes", 32'(wr_count), 32'h0);
        end
        enable = 1'b1;
        wait_quit("freeze", cyc);
        check("freeze/final_wr", 32'(dut.regs[0]), 32'h09);
        check("freeze/final_writes", 32'(wr_count), 32'h1);
        check("freeze/final_waddr", 32'(last_addr), 32'h07);
        check("freeze/final_wdata", 32'(last_data), 32'h09);

        // Reset during the store cycle aborts it without writing; program then reruns cleanly.
        start_prog("abort", p027);
        wait_addr("abort", 8'h07);
        reset = 1'b1;
        @(negedge clk);
        check("abort/writes", 32'(wr_count), 32'h0);
        check("abort/addr", 32'(addr), 32'h0);
        check("abort/quit", 32'(quit), 32'h0);
        reset = 1'b0;
        wait_quit("abort", cyc);
        check("abort/rerun_wr", 32'(dut.regs[0]), 32'h09);
        check("abort/rerun_writes", 32'(wr_count), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/relfet_cpu_core.md
RELFET_CPU_CORE -- requirements
Module: reflet_cpu_core

Interface
REQ-001 SHALL have parameter wordsize, default 16: data/address/register width W (W >= 8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  high = run; low = freeze all state.
REQ-005 SHALL have port data_in  input  W  memory read data, valid one cycle after addr is presented.
REQ-006 SHALL have port ext_int  input  4  external interrupt lines, reserved and ignored in this revision.
REQ-007 SHALL have port addr  output  W  word address to memory.
REQ-008 SHALL have port data_out  output  W  memory write data.
REQ-009 SHALL have port write_en  output  1  memory write strobe, one cycle per store.
REQ-010 SHALL have port quit  output  1  sticky high after the quit instruction.

Function
REQ-011 SHALL hold 16 W-bit registers: R0=WR (accumulator), R1-R11 and R15 general, R12=SR (bit0 = condition flag), R13=SP, R14=PC.
REQ-012 SHALL decode instruction from data_in[7:0]: opcode = bits[7:4], operand x = bits[3:0].
REQ-013 SHALL run state machine FETCH -> DECODE, and for memory instructions DECODE -> MEM -> MEMWAIT -> FETCH; all others DECODE -> FETCH.
REQ-014 FETCH SHALL drive addr=PC, write_en=0; DECODE SHALL latch instruction from data_in, execute, and update PC.
REQ-015 Non-jump instructions SHALL advance PC by 1 (modulo 2^W); reading R14 SHALL return the current instruction's address.
REQ-016 Opcodes 0x1-0xF: set x (WR<=zero-ext x), read (WR<=Rx), cpy (Rx<=WR), add, sub, and, or, xor (WR<=WR op Rx, wrap modulo 2^W), not (WR<=~Rx), lsl (WR<=WR<<Rx), lsr (WR<=WR>>Rx, logical), eq (SR[0]<=WR==Rx), les (SR[0]<=WR<Rx unsigned), str (mem[Rx]<=WR), load (WR<=mem[Rx]).
REQ-017 Opcode 0x0 SHALL encode: 0x00 slp (no-op), 0x01 cmpnot (SR[0]<=~SR[0]), 0x03 jif (PC<=WR if SR[0] else PC+1), 0x04 pop (WR<=mem[SP], SP<=SP+1), 0x05 push (SP<=SP-1, mem[SP-1]<=WR), 0x06 call (push PC+1, PC<=WR), 0x07 ret (pop into PC), 0x08 quit; other 0x0y SHALL act as slp.
REQ-018 cpy to R14 SHALL jump (PC<=WR, no increment); cpy to R0 SHALL be a no-op.
REQ-019 MEM SHALL drive the operand address on addr; stores assert write_en=1 with data_out valid for that single cycle; loads capture data_in in MEMWAIT.
REQ-020 quit SHALL set quit=1 and halt in a QUIT state (no fetches, write_en=0) until reset.
REQ-021 enable=0 SHALL freeze state, registers and outputs held except write_en forced 0; resumes from the same state when enable returns high.
REQ-022 SP arithmetic SHALL wrap modulo 2^W; only the low W bits of results are kept.
REQ-023 data_out SHALL equal WR (or PC+1 for call) whenever write_en=1; otherwise unspecified.

Reset
REQ-024 reset=1 at a rising edge SHALL clear all registers (PC=0, SP=0, SR=0), set state FETCH, quit=0, write_en=0; reset SHALL take priority over enable and abort any in-flight instruction without a write.
REQ-025 First fetch after reset release SHALL present addr=0.

Verification (W=8, memory with 1-cycle read latency)
REQ-026 Program 0x15,0x31,0x13,0x41,0x08 (set 5, cpy R1, set 3, add R1, quit) -> WR=8, quit=1 within 12 cycles, no write_en.
REQ-027 set 7, cpy R2, set 9, str R2 -> exactly one write_en pulse with addr=7, data_out=9.
REQ-028 set 4, cpy R3, set 4, eq R3, set 0xA (WR=10), jif -> next fetch addr=10; with cmpnot inserted before jif -> fall through to PC+1.
REQ-029 set 6, push, set 0, pop -> write at addr=0xFF data 6, then WR=6, SP=0.
REQ-030 Hold enable=0 for 15 cycles mid-program -> addr/registers constant, write_en=0; final results identical to uninterrupted run.
REQ-031 Assert reset after quit -> quit=0, next fetch addr=0, program re-executes.
